// File: rtl/jump_key_conditioner.sv
// jump_key_conditioner
// Conditions a raw, bouncing jump button into a debounced level, a one-cycle
// press pulse and a pending-press flag that the frame-rate controller consumes.
// The press counter and the sticky overrun flag give software visibility into
// presses that arrive faster than frames consume them.
//
// Pending-press protocol: jump_key rises on an accepted press and stays high
// until the downstream controller pulses frame_tick for one cycle. A press
// accepted in the same cycle as frame_tick replaces the consumed one, so
// jump_key stays high. A press accepted while jump_key is already high and no
// frame_tick is present raises overrun, which holds until overrun_clr.
module jump_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 21
) (
  input  logic       proc_clk,
  input  logic       reset,
  input  logic       key_raw,
  input  logic       frame_tick,
  input  logic       overrun_clr,
  output logic       jump_key,
  output logic       key_level,
  output logic       press_pulse,
  output logic       overrun,
  output logic [7:0] press_count,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHK_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    CHK_LOW     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             key_meta;
  logic             key_sync;
  logic             press_event;

  // FSM state is visible for checkers and debug.
  assign fsm_state = state;

  // Two-flop synchronizer; only key_sync is used downstream.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
    end
  end

  // A press is accepted on the sample that completes a high-going check.
  always_comb begin
    press_event = 1'b0;
    if ((state == CHK_HIGH) && key_sync && (cnt == CNT_LAST)) begin
      press_event = 1'b1;
    end
  end

  // Debounce FSM with counter; key_level and press_pulse are registered here.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      state       <= STABLE_LOW;
      cnt         <= '0;
      key_level   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (key_sync) begin
            state <= CHK_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        CHK_HIGH: begin
          if (!key_sync) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= STABLE_HIGH;
            cnt         <= '0;
            key_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!key_sync) begin
            state <= CHK_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        CHK_LOW: begin
          if (key_sync) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= STABLE_LOW;
            cnt       <= '0;
            key_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= STABLE_LOW;
          cnt       <= '0;
          key_level <= 1'b0;
        end
      endcase
    end
  end

  // Pending-press flag, sticky overrun (set wins over clear) and press counter.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      jump_key    <= 1'b0;
      overrun     <= 1'b0;
      press_count <= 8'd0;
    end else begin
      jump_key <= press_event | (jump_key & ~frame_tick);
      if (press_event && jump_key && !frame_tick) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
      if (press_event) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_jump_key_conditioner.sv
// Directed bench for jump_key_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_jump_key_conditioner;

  logic       proc_clk;
  logic       reset;
  logic       key_raw;
  logic       frame_tick;
  logic       overrun_clr;
  logic       jump_key;
  logic       key_level;
  logic       press_pulse;
  logic       overrun;
  logic [7:0] press_count;
  logic [1:0] fsm_state;

  int vectors;
  int miscompares;

  jump_key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .proc_clk(proc_clk),
    .reset(reset),
    .key_raw(key_raw),
    .frame_tick(frame_tick),
    .overrun_clr(overrun_clr),
    .jump_key(jump_key),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .overrun(overrun),
    .press_count(press_count),
    .fsm_state(fsm_state)
  );

  // Clock and reset block
  initial proc_clk = 1'b0;
  always #5 proc_clk = ~proc_clk;

  // Advance n rising edges, then settle 1 ns.
  task automatic step(input int n);
    repeat (n) @(posedge proc_clk);
    #1;
  endtask

  // Pulse reset low for two edges, leaving all inputs idle.
  task automatic do_reset();
    key_raw     = 1'b0;
    frame_tick  = 1'b0;
    overrun_clr = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  // Full press: hold high long enough to be accepted, then release and settle.
  task automatic press_key();
    key_raw = 1'b1;
    step(8);
    key_raw = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    key_raw     = 1'b0;
    frame_tick  = 1'b0;
    overrun_clr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({jump_key, key_level, press_pulse, overrun, press_count, fsm_state} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %b expected 0",
               {jump_key, key_level, press_pulse, overrun, press_count, fsm_state});
    end
    step(3);
    reset = 1'b1;
    step(3);
    vectors++;
    if ({jump_key, key_level, press_pulse, overrun, press_count, fsm_state} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_idle: got %b expected 0",
               {jump_key, key_level, press_pulse, overrun, press_count, fsm_state});
    end
  endtask

  task automatic test_glitch();
    int pulses;
    bit level_seen;
    bit jump_seen;
    bit chk_seen;
    pulses     = 0;
    level_seen = 1'b0;
    jump_seen  = 1'b0;
    chk_seen   = 1'b0;
    for (int r = 0; r < 5; r++) begin
      key_raw = 1'b1;
      for (int c = 0; c < 3; c++) begin
        step(1);
        if (press_pulse) pulses++;
        if (key_level) level_seen = 1'b1;
        if (jump_key) jump_seen = 1'b1;
        if (fsm_state == 2'd1) chk_seen = 1'b1;
      end
      key_raw = 1'b0;
      for (int c = 0; c < 6; c++) begin
        step(1);
        if (press_pulse) pulses++;
        if (key_level) level_seen = 1'b1;
        if (jump_key) jump_seen = 1'b1;
        if (fsm_state == 2'd1) chk_seen = 1'b1;
      end
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL glitch_pulse: got %0d pulses expected 0", pulses);
    end
    vectors++;
    if (level_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_level: got %0b expected 0", level_seen);
    end
    vectors++;
    if (jump_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_jump: got %0b expected 0", jump_seen);
    end
    vectors++;
    if (press_count !== 8'd0) begin
      miscompares++;
      $display("FAIL glitch_count: got %0d expected 0", press_count);
    end
    vectors++;
    if (chk_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_chk_entered: got %0b expected 1", chk_seen);
    end
    vectors++;
    if (fsm_state !== 2'd0) begin
      miscompares++;
      $display("FAIL glitch_state: got %0d expected 0", fsm_state);
    end
  endtask

  task automatic test_press();
    int pulses;
    logic exp_b;
    key_raw = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      exp_b = (e == 6);
      vectors++;
      if (key_level !== exp_b) begin
        miscompares++;
        $display("FAIL press_level_e%0d: got %0b expected %0b", e, key_level, exp_b);
      end
      vectors++;
      if (press_pulse !== exp_b) begin
        miscompares++;
        $display("FAIL press_pulse_e%0d: got %0b expected %0b", e, press_pulse, exp_b);
      end
    end
    vectors++;
    if (jump_key !== 1'b1) begin
      miscompares++;
      $display("FAIL press_jump: got %0b expected 1", jump_key);
    end
    vectors++;
    if (press_count !== 8'd1) begin
      miscompares++;
      $display("FAIL press_count: got %0d expected 1", press_count);
    end
    vectors++;
    if (fsm_state !== 2'd2) begin
      miscompares++;
      $display("FAIL press_state: got %0d expected 2", fsm_state);
    end
    pulses = 0;
    for (int e = 7; e <= 20; e++) begin
      step(1);
      if (press_pulse) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL hold_extra_pulse: got %0d pulses expected 0", pulses);
    end
    vectors++;
    if (key_level !== 1'b1 || press_count !== 8'd1) begin
      miscompares++;
      $display("FAIL hold_state: got level %0b count %0d expected level 1 count 1",
               key_level, press_count);
    end
    key_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      if (press_pulse) pulses++;
      exp_b = (e < 6);
      vectors++;
      if (key_level !== exp_b) begin
        miscompares++;
        $display("FAIL release_level_e%0d: got %0b expected %0b", e, key_level, exp_b);
      end
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL release_pulse: got %0d pulses expected 0", pulses);
    end
    vectors++;
    if (jump_key !== 1'b1 || press_count !== 8'd1) begin
      miscompares++;
      $display("FAIL release_pending: got jump %0b count %0d expected jump 1 count 1",
               jump_key, press_count);
    end
  endtask

  task automatic test_frame_tick();
    step(10);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    vectors++;
    if (jump_key !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_consume: got %0b expected 0", jump_key);
    end
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
    vectors++;
    if (jump_key !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_idle: got jump %0b overrun %0b expected 0 0", jump_key, overrun);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    press_key();
    vectors++;
    if (overrun !== 1'b0 || jump_key !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_first: got overrun %0b jump %0b expected 0 1", overrun, jump_key);
    end
    press_key();
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set: got %0b expected 1", overrun);
    end
    vectors++;
    if (press_count !== 8'd2) begin
      miscompares++;
      $display("FAIL ovr_count: got %0d expected 2", press_count);
    end
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b0 || jump_key !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_clear: got overrun %0b jump %0b expected 0 1", overrun, jump_key);
    end
    // Third press with overrun_clr on the acceptance edge: set must win.
    key_raw = 1'b1;
    step(5);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    vectors++;
    if (press_pulse !== 1'b1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set_wins: got pulse %0b overrun %0b expected 1 1", press_pulse, overrun);
    end
    key_raw = 1'b0;
    step(8);
    vectors++;
    if (press_count !== 8'd3) begin
      miscompares++;
      $display("FAIL ovr_count3: got %0d expected 3", press_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press_key();
    key_raw = 1'b1;
    step(5);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    vectors++;
    if (press_pulse !== 1'b1 || jump_key !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_edge: got pulse %0b jump %0b expected 1 1", press_pulse, jump_key);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_overrun: got %0b expected 0", overrun);
    end
    step(1);
    vectors++;
    if (jump_key !== 1'b1 || press_count !== 8'd2) begin
      miscompares++;
      $display("FAIL b2b_after: got jump %0b count %0d expected 1 2", jump_key, press_count);
    end
    key_raw = 1'b0;
    step(8);
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic exp_b;
    do_reset();
    press_key();
    key_raw = 1'b1;
    step(4);
    vectors++;
    if (fsm_state !== 2'd1 || jump_key !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: got state %0d jump %0b expected 1 1", fsm_state, jump_key);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({jump_key, key_level, press_pulse, overrun, press_count, fsm_state} !== 13'd0) begin
      miscompares++;
      $display("FAIL mid_async: got %b expected 0",
               {jump_key, key_level, press_pulse, overrun, press_count, fsm_state});
    end
    step(2);
    reset = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      if (press_pulse) pulses++;
      exp_b = (e == 6);
      vectors++;
      if (press_pulse !== exp_b) begin
        miscompares++;
        $display("FAIL mid_pulse_e%0d: got %0b expected %0b", e, press_pulse, exp_b);
      end
    end
    for (int e = 7; e <= 16; e++) begin
      step(1);
      if (press_pulse) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL mid_pulse_total: got %0d expected 1", pulses);
    end
    vectors++;
    if (press_count !== 8'd1) begin
      miscompares++;
      $display("FAIL mid_count: got %0d expected 1", press_count);
    end
    key_raw = 1'b0;
    step(8);
  endtask

  // Test sequence and final report
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    key_raw     = 1'b0;
    frame_tick  = 1'b0;
    overrun_clr = 1'b0;
    test_reset();
    test_glitch();
    test_press();
    test_frame_tick();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
